// File: rtl/dpdm_rx.sv
// Receive-side DP/DM front end: registers the line pair, hunts for SYNC, forwards
// post-SYNC packet bits one per cycle and checks the SE0-SE0-J end-of-packet.
module dpdm_rx #(
  parameter int unsigned MAX_BITS = 84,
  parameter int unsigned MIN_BITS = 4
) (
  input  logic       clk,
  input  logic       rst_b,
  input  logic       re,
  input  logic       dp,
  input  logic       dm,
  output logic       bstr,
  output logic       bstr_valid,
  output logic       pkt_start,
  output logic       pkt_end,
  output logic       rx_err,
  output logic [6:0] bit_cnt,
  output logic       busy
);

  localparam logic [6:0] MaxBits = MAX_BITS[6:0];
  localparam logic [6:0] MinBits = MIN_BITS[6:0];

  typedef enum logic [2:0] {
    StIdle,
    StSync,
    StData,
    StEop1,
    StEop2,
    StErr
  } state_e;

  state_e     r_state, w_state;
  logic       r_dp_q, r_dm_q;
  logic [2:0] r_sync_idx, w_sync_idx;
  logic       r_j_cnt, w_j_cnt;
  logic       r_bstr, w_bstr;
  logic       r_bstr_valid, w_bstr_valid;
  logic       r_pkt_start, w_pkt_start;
  logic       r_pkt_end, w_pkt_end;
  logic       r_rx_err, w_rx_err;
  logic [6:0] r_bit_cnt, w_bit_cnt;
  logic       r_busy, w_busy;

  logic w_is_j, w_is_k, w_is_se0, w_is_se1;
  logic w_sync_exp_k, w_sync_match;

  always_comb begin
    w_is_j   = r_dp_q & ~r_dm_q;
    w_is_k   = ~r_dp_q & r_dm_q;
    w_is_se0 = ~r_dp_q & ~r_dm_q;
    w_is_se1 = r_dp_q & r_dm_q;
    // SYNC pattern K J K J K J K K: K at even indices and at the final index
    w_sync_exp_k = ~r_sync_idx[0] | (r_sync_idx == 3'd7);
    w_sync_match = w_sync_exp_k ? w_is_k : w_is_j;
  end

  always_comb begin
    w_state      = r_state;
    w_sync_idx   = r_sync_idx;
    w_j_cnt      = r_j_cnt;
    w_bstr       = r_bstr;
    w_bstr_valid = 1'b0;
    w_pkt_start  = 1'b0;
    w_pkt_end    = 1'b0;
    w_bit_cnt    = r_bit_cnt;

    unique case (r_state)
      StIdle: begin
        if (re && w_is_k) begin
          w_state    = StSync;
          w_sync_idx = 3'd1;
          w_bit_cnt  = 7'd0;
        end
      end
      StSync: begin
        if (!re) begin
          w_state   = StIdle;
          w_bit_cnt = 7'd0;
        end else if (!w_sync_match) begin
          w_state = StErr;
        end else if (r_sync_idx == 3'd7) begin
          w_state     = StData;
          w_pkt_start = 1'b1;
        end else begin
          w_sync_idx = r_sync_idx + 3'd1;
        end
      end
      StData: begin
        if (!re) begin
          w_state   = StIdle;
          w_bit_cnt = 7'd0;
        end else if (w_is_se1) begin
          w_state = StErr;
        end else if (w_is_se0) begin
          w_state = StEop1;
        end else if (r_bit_cnt >= MaxBits) begin
          w_state = StErr;
        end else begin
          w_bstr       = r_dp_q;
          w_bstr_valid = 1'b1;
          w_bit_cnt    = (r_bit_cnt == 7'h7f) ? r_bit_cnt : r_bit_cnt + 7'd1;
        end
      end
      StEop1: begin
        if (!re) begin
          w_state   = StIdle;
          w_bit_cnt = 7'd0;
        end else if (w_is_se0) begin
          w_state = StEop2;
        end else begin
          w_state = StErr;
        end
      end
      StEop2: begin
        if (!re) begin
          w_state   = StIdle;
          w_bit_cnt = 7'd0;
        end else if (w_is_j && (r_bit_cnt >= MinBits)) begin
          w_state   = StIdle;
          w_pkt_end = 1'b1;
        end else begin
          w_state = StErr;
        end
      end
      StErr: begin
        if (w_is_j) begin
          if (r_j_cnt) begin
            w_state = StIdle;
          end else begin
            w_j_cnt = 1'b1;
          end
        end else begin
          w_j_cnt = 1'b0;
        end
      end
      default: w_state = StIdle;
    endcase

    // Recovery needs two fresh J symbols counted from the cycle after entry
    if (r_state != StErr) begin
      w_j_cnt = 1'b0;
    end
    w_rx_err = (w_state == StErr) && (r_state != StErr);
    w_busy   = (w_state != StIdle);
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_dp_q       <= 1'b1;
      r_dm_q       <= 1'b0;
      r_state      <= StIdle;
      r_sync_idx   <= 3'd0;
      r_j_cnt      <= 1'b0;
      r_bstr       <= 1'b0;
      r_bstr_valid <= 1'b0;
      r_pkt_start  <= 1'b0;
      r_pkt_end    <= 1'b0;
      r_rx_err     <= 1'b0;
      r_bit_cnt    <= 7'd0;
      r_busy       <= 1'b0;
    end else begin
      r_dp_q       <= dp;
      r_dm_q       <= dm;
      r_state      <= w_state;
      r_sync_idx   <= w_sync_idx;
      r_j_cnt      <= w_j_cnt;
      r_bstr       <= w_bstr;
      r_bstr_valid <= w_bstr_valid;
      r_pkt_start  <= w_pkt_start;
      r_pkt_end    <= w_pkt_end;
      r_rx_err     <= w_rx_err;
      r_bit_cnt    <= w_bit_cnt;
      r_busy       <= w_busy;
    end
  end

  assign bstr       = r_bstr;
  assign bstr_valid = r_bstr_valid;
  assign pkt_start  = r_pkt_start;
  assign pkt_end    = r_pkt_end;
  assign rx_err     = r_rx_err;
  assign bit_cnt    = r_bit_cnt;
  assign busy       = r_busy;

endmodule

// File: tb/tb_dpdm_rx.sv
// Directed bench for dpdm_rx: drives line symbols on the falling edge and checks
// forwarded bits, pulses and counters against hand-computed expectations.
module tb_dpdm_rx;

  logic       clk = 1'b0;
  logic       rst_b, re, dp, dm;
  logic       bstr, bstr_valid, pkt_start, pkt_end, rx_err, busy;
  logic [6:0] bit_cnt;

  dpdm_rx #(
    .MAX_BITS(84),
    .MIN_BITS(4)
  ) u_dut (
    .clk       (clk),
    .rst_b     (rst_b),
    .re        (re),
    .dp        (dp),
    .dm        (dm),
    .bstr      (bstr),
    .bstr_valid(bstr_valid),
    .pkt_start (pkt_start),
    .pkt_end   (pkt_end),
    .rx_err    (rx_err),
    .bit_cnt   (bit_cnt),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int n_start, n_end, n_err, start_cyc, drive_cyc;
  int n_viol = 0;
  bit got_q[$];
  bit exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Monitor samples 1 time unit after each rising edge
  initial begin
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (bstr_valid) got_q.push_back(bstr);
      if (pkt_start) begin
        n_start++;
        start_cyc = cyc;
      end
      if (pkt_end) n_end++;
      if (rx_err) n_err++;
      if ((int'(pkt_start) + int'(pkt_end) + int'(rx_err)) > 1) n_viol++;
      if ((pkt_end || rx_err) && bstr_valid) n_viol++;
    end
  end

  task automatic clear_mon();
    n_start = 0;
    n_end   = 0;
    n_err   = 0;
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic sym(input logic d, input logic m);
    @(negedge clk);
    dp = d;
    dm = m;
  endtask

  task automatic idle(input int n);
    repeat (n) sym(1'b1, 1'b0);
  endtask

  task automatic sync_field();
    sym(0, 1); sym(1, 0); sym(0, 1); sym(1, 0);
    sym(0, 1); sym(1, 0); sym(0, 1); sym(0, 1);
    drive_cyc = cyc;
  endtask

  task automatic data_bits(input int n, input int seed);
    for (int i = 0; i < n; i++) begin
      bit b;
      b = ((i + seed) % 3) != 0;
      exp_q.push_back(b);
      sym(b, ~b);
    end
  endtask

  task automatic eop();
    sym(0, 0); sym(0, 0); sym(1, 0);
  endtask

  task automatic compare_bits(input string tag);
    int mism;
    mism = 0;
    check({tag, "_len"}, got_q.size(), exp_q.size());
    if (got_q.size() == exp_q.size()) begin
      for (int i = 0; i < got_q.size(); i++) if (got_q[i] != exp_q[i]) mism++;
    end
    check({tag, "_bits"}, mism, 0);
  endtask

  task automatic fault_case(input string tag, input int kind);
    clear_mon();
    idle(3);
    sync_field();
    data_bits(5, kind);
    case (kind)
      0: sym(1, 1);
      1: begin sym(0, 0); sym(1, 0); end
      default: begin sym(0, 0); sym(0, 0); sym(0, 1); end
    endcase
    idle(4);
    check({tag, "_err"}, n_err, 1);
    check({tag, "_end"}, n_end, 0);
    check({tag, "_valid"}, got_q.size(), 5);
  endtask

  initial begin
    rst_b = 1'b0;
    re    = 1'b1;
    dp    = 1'b1;
    dm    = 1'b0;
    clear_mon();
    #2;
    check("reset_outs", {bstr, bstr_valid, pkt_start, pkt_end, rx_err, busy, bit_cnt}, 0);
    repeat (2) @(negedge clk);
    rst_b = 1'b1;
    idle(2);
    check("reset_idle_busy", busy, 0);

    // Handshake: K,J,J,K -> bstr 0,1,1,0
    clear_mon();
    idle(3);
    sync_field();
    sym(0, 1); exp_q.push_back(1'b0);
    sym(1, 0); exp_q.push_back(1'b1);
    sym(1, 0); exp_q.push_back(1'b1);
    sym(0, 1); exp_q.push_back(1'b0);
    eop();
    idle(4);
    check("hs_start", n_start, 1);
    check("hs_start_lat", start_cyc - drive_cyc, 2);
    check("hs_end", n_end, 1);
    check("hs_err", n_err, 0);
    check("hs_cnt", bit_cnt, 4);
    compare_bits("hs");

    // Largest legal payload
    clear_mon();
    idle(3);
    sync_field();
    data_bits(84, 0);
    eop();
    idle(4);
    check("max_end", n_end, 1);
    check("max_err", n_err, 0);
    check("max_cnt", bit_cnt, 84);
    compare_bits("max");

    // One bit too many
    clear_mon();
    idle(3);
    sync_field();
    data_bits(85, 1);
    eop();
    idle(4);
    void'(exp_q.pop_back());
    check("ovf_err", n_err, 1);
    check("ovf_end", n_end, 0);
    check("ovf_cnt", bit_cnt, 84);
    compare_bits("ovf");

    // Corrupted SYNC, two J, then a good packet
    clear_mon();
    idle(3);
    sym(0, 1); sym(1, 0); sym(0, 1); sym(0, 1);
    idle(2);
    sync_field();
    data_bits(8, 2);
    eop();
    idle(4);
    check("sync_err", n_err, 1);
    check("sync_start", n_start, 1);
    check("sync_end", n_end, 1);
    compare_bits("sync");

    fault_case("se1", 0);
    fault_case("se0j", 1);
    fault_case("se0se0k", 2);

    // Short packet
    clear_mon();
    idle(3);
    sync_field();
    data_bits(2, 0);
    eop();
    idle(4);
    check("short_err", n_err, 1);
    check("short_end", n_end, 0);
    check("short_cnt", bit_cnt, 2);

    // Receive enable dropped mid-packet
    clear_mon();
    idle(3);
    sync_field();
    data_bits(10, 1);
    sym(1, 0);
    @(negedge clk);
    check("abort_cnt_before", bit_cnt, 10);
    check("abort_busy_before", busy, 1);
    re = 1'b0;
    dp = 1'b1;
    dm = 1'b0;
    @(negedge clk);
    check("abort_busy", busy, 0);
    check("abort_cnt", bit_cnt, 0);
    idle(3);
    check("abort_pulses", n_end + n_err, 0);
    check("abort_valid", got_q.size(), 10);
    re = 1'b1;
    idle(2);

    // Asynchronous reset mid-DATA, then a clean packet
    clear_mon();
    idle(3);
    sync_field();
    data_bits(6, 2);
    idle(1);
    @(negedge clk);
    check("rst_busy_before", busy, 1);
    rst_b = 1'b0;
    #1;
    check("rst_mid_outs", {bstr, bstr_valid, pkt_start, pkt_end, rx_err, busy, bit_cnt}, 0);
    @(negedge clk);
    rst_b = 1'b1;
    clear_mon();
    idle(3);
    sync_field();
    data_bits(5, 0);
    eop();
    idle(4);
    check("rst_pkt_end", n_end, 1);
    check("rst_pkt_err", n_err, 0);
    compare_bits("rst_pkt");

    check("exclusive_pulses", n_viol, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
